// File: rtl/id_ex_pkg.sv
// Shared types and constants for the elastic ID/EX pipeline register.
package id_ex_pkg;

  // Default payload geometry
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_CTRL_W = 10;
  localparam int unsigned DEF_REG_AW = 5;

  // Bit positions inside the decoded control word
  localparam int unsigned CTRL_REGWRITE = 9;
  localparam int unsigned CTRL_MEMTOREG = 8;
  localparam int unsigned CTRL_MEMWRITE = 7;
  localparam int unsigned CTRL_MEMREAD  = 6;
  localparam int unsigned CTRL_ALUSRC   = 5;
  localparam int unsigned CTRL_ALUOP_HI = 4;
  localparam int unsigned CTRL_ALUOP_LO = 1;
  localparam int unsigned CTRL_REGDST   = 0;

  // Occupancy of the MAIN/SKID slot pair
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  // Payload layout at default widths; the top packs fields in the same order
  typedef struct packed {
    logic [DEF_CTRL_W-1:0] ctrl;
    logic [DEF_DATA_W-1:0] pc4;
    logic [DEF_DATA_W-1:0] rd1;
    logic [DEF_DATA_W-1:0] rd2;
    logic [DEF_DATA_W-1:0] imm;
    logic [DEF_REG_AW-1:0] rs;
    logic [DEF_REG_AW-1:0] rt;
    logic [DEF_REG_AW-1:0] rd;
  } payload_t;

endpackage

// File: rtl/id_ex_pipe_reg_skid_slot.sv
// One payload register with load enable; used for both the MAIN and SKID slots.
module pipe_skid_slot #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Capture d when load is asserted; cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// Elastic ID/EX pipeline register: two-entry skid buffer with registered
// in_ready, synchronous flush and bubble masking of the control word.
module id_ex_pipe_reg
  import id_ex_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned CTRL_W = DEF_CTRL_W,
  parameter int unsigned REG_AW = DEF_REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  // Decode side
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_pc4,
  input  logic [DATA_W-1:0] in_rd1,
  input  logic [DATA_W-1:0] in_rd2,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [REG_AW-1:0] in_rs,
  input  logic [REG_AW-1:0] in_rt,
  input  logic [REG_AW-1:0] in_rd,
  // Hazard unit
  input  logic              flush,
  // Execute side
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_pc4,
  output logic [DATA_W-1:0] out_rd1,
  output logic [DATA_W-1:0] out_rd2,
  output logic [DATA_W-1:0] out_imm,
  output logic [REG_AW-1:0] out_rs,
  output logic [REG_AW-1:0] out_rt,
  output logic [REG_AW-1:0] out_rd,
  output logic [1:0]        occupancy
);

  localparam int unsigned PayW = CTRL_W + 4 * DATA_W + 3 * REG_AW;

  state_e          state_q, state_d;
  logic            in_ready_q, in_ready_d;
  logic            in_fire, out_fire;
  logic            main_load, skid_load, main_from_skid;
  logic [PayW-1:0] in_pay, main_d, main_q, skid_q;
  logic [CTRL_W-1:0] main_ctrl;

  assign in_pay = {in_ctrl, in_pc4, in_rd1, in_rd2, in_imm, in_rs, in_rt, in_rd};

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid & out_ready;

  // Next-state and slot load decisions; flush overrides every handshake
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_load = 1'b1;
          state_d   = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_load = 1'b1;
        end else if (in_fire) begin
          skid_load = 1'b1;
          state_d   = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          state_d        = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      // Squashed data is never loaded; stale slot contents are harmless
      state_d   = EMPTY;
      main_load = 1'b0;
      skid_load = 1'b0;
    end
  end

  // in_ready is registered so out_ready never reaches it combinationally
  assign in_ready_d = (state_d != FULL);

  // State and ready flops; in_ready stays low until the first edge after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign main_d = main_from_skid ? skid_q : in_pay;

  pipe_skid_slot #(
    .WIDTH (PayW)
  ) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (main_load),
    .d     (main_d),
    .q     (main_q)
  );

  pipe_skid_slot #(
    .WIDTH (PayW)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (skid_load),
    .d     (in_pay),
    .q     (skid_q)
  );

  assign {main_ctrl, out_pc4, out_rd1, out_rd2, out_imm, out_rs, out_rt, out_rd} = main_q;

  // A bubble must never carry RegWrite/MemWrite/MemRead downstream
  assign out_ctrl = main_ctrl & {CTRL_W{out_valid}};

  // Occupancy decode
  always_comb begin
    occupancy = 2'd0;
    unique case (state_q)
      EMPTY:   occupancy = 2'd0;
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed self-checking bench for id_ex_pipe_reg.
module tb_id_ex_pipe_reg;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  in_ctrl;
  logic [31:0] in_pc4, in_rd1, in_rd2, in_imm;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  out_ctrl;
  logic [31:0] out_pc4, out_rd1, out_rd2, out_imm;
  logic [4:0]  out_rs, out_rt, out_rd;
  logic [1:0]  occupancy;

  int checks;
  int failures;

  id_ex_pipe_reg #(
    .DATA_W (32),
    .CTRL_W (10),
    .REG_AW (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_pc4    (in_pc4),
    .in_rd1    (in_rd1),
    .in_rd2    (in_rd2),
    .in_imm    (in_imm),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_rd     (in_rd),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_pc4   (out_pc4),
    .out_rd1   (out_rd1),
    .out_rd2   (out_rd2),
    .out_imm   (out_imm),
    .out_rs    (out_rs),
    .out_rt    (out_rt),
    .out_rd    (out_rd),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction; side fields are simple functions of pc4
  task automatic drive(input logic v, input logic [31:0] pc4, input logic [9:0] ctrl);
    in_valid = v;
    in_pc4   = pc4;
    in_ctrl  = ctrl;
    in_rd1   = pc4 ^ 32'hA5A5_0000;
    in_rd2   = ~pc4;
    in_imm   = pc4 << 4;
    in_rs    = pc4[6:2];
    in_rt    = pc4[6:2] + 5'd1;
    in_rd    = pc4[6:2] + 5'd2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    out_ready = 1'b0;
    flush = 1'b0;
    drive(1'b0, 32'h0, 10'h0);
    repeat (3) tick();
    checks++; if (out_valid !== 1'b0) begin failures++;
      $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin failures++;
      $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (occupancy !== 2'd0) begin failures++;
      $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
    checks++; if (out_ctrl !== 10'h000 || out_pc4 !== 32'h0) begin failures++;
      $display("FAIL reset_payload: ctrl=%h pc4=%h expected 000/0", out_ctrl, out_pc4); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++;
      $display("FAIL release_in_ready_early: got %b expected 0", in_ready); end
    tick();
    checks++; if (in_ready !== 1'b1) begin failures++;
      $display("FAIL release_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_stream();
    logic [31:0] pcs [3];
    pcs[0] = 32'h4; pcs[1] = 32'h8; pcs[2] = 32'hC;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, pcs[i], 10'h201);
      tick();
      checks++; if (out_valid !== 1'b1 || out_pc4 !== pcs[i]) begin failures++;
        $display("FAIL stream_pc4[%0d]: valid=%b pc4=%h expected 1/%h", i, out_valid, out_pc4,
                 pcs[i]); end
      checks++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin failures++;
        $display("FAIL stream_occ[%0d]: occ=%0d in_ready=%b expected 1/1", i, occupancy,
                 in_ready); end
    end
    // Last beat carried pc4=0xC: rs=3 rt=4 rd=5, imm=0xC0
    checks++; if (out_rd1 !== 32'hA5A5_000C || out_rd2 !== 32'hFFFF_FFF3 || out_imm !== 32'hC0
                  || out_rs !== 5'd3 || out_rt !== 5'd4 || out_rd !== 5'd5
                  || out_ctrl !== 10'h201) begin failures++;
      $display("FAIL stream_fields: rd1=%h rd2=%h imm=%h rs=%0d rt=%0d rd=%0d ctrl=%h", out_rd1,
               out_rd2, out_imm, out_rs, out_rt, out_rd, out_ctrl); end
    drive(1'b0, 32'h0, 10'h0);
    tick();
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin failures++;
      $display("FAIL stream_drain: valid=%b occ=%0d expected 0/0", out_valid, occupancy); end
  endtask

  task automatic test_stall();
    out_ready = 1'b1;
    drive(1'b1, 32'h10, 10'h041);
    tick();
    out_ready = 1'b0;
    drive(1'b1, 32'h14, 10'h042);
    tick();
    checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin failures++;
      $display("FAIL stall_full: occ=%0d in_ready=%b expected 2/0", occupancy, in_ready); end
    checks++; if (out_pc4 !== 32'h10 || out_valid !== 1'b1) begin failures++;
      $display("FAIL stall_head: pc4=%h valid=%b expected 10/1", out_pc4, out_valid); end
    // Keep offering a beat: it must not be taken while full
    drive(1'b1, 32'h18, 10'h043);
    tick();
    checks++; if (occupancy !== 2'd2 || out_pc4 !== 32'h10) begin failures++;
      $display("FAIL stall_hold: occ=%0d pc4=%h expected 2/10", occupancy, out_pc4); end
    drive(1'b0, 32'h0, 10'h0);
    out_ready = 1'b1;
    tick();
    checks++; if (out_pc4 !== 32'h14 || out_ctrl !== 10'h042 || occupancy !== 2'd1)
      begin failures++;
      $display("FAIL stall_skid_order: pc4=%h ctrl=%h occ=%0d expected 14/042/1", out_pc4,
               out_ctrl, occupancy); end
    checks++; if (in_ready !== 1'b1) begin failures++;
      $display("FAIL stall_ready_back: got %b expected 1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++;
      $display("FAIL stall_drain: valid=%b expected 0", out_valid); end
  endtask

  task automatic test_flush_full();
    out_ready = 1'b0;
    drive(1'b1, 32'h20, 10'h2AA);
    tick();
    drive(1'b1, 32'h24, 10'h2AA);
    tick();
    checks++; if (occupancy !== 2'd2) begin failures++;
      $display("FAIL flush_full_setup: occ=%0d expected 2", occupancy); end
    drive(1'b0, 32'h0, 10'h0);
    flush = 1'b1;
    out_ready = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_ctrl !== 10'h000 || occupancy !== 2'd0)
      begin failures++;
      $display("FAIL flush_full: valid=%b ctrl=%h occ=%0d expected 0/000/0", out_valid,
               out_ctrl, occupancy); end
    checks++; if (in_ready !== 1'b1) begin failures++;
      $display("FAIL flush_full_ready: got %b expected 1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++;
      $display("FAIL flush_full_no_deliver: valid=%b pc4=%h expected invalid", out_valid,
               out_pc4); end
  endtask

  task automatic test_flush_input();
    out_ready = 1'b0;
    drive(1'b1, 32'h2C, 10'h011);
    tick();
    drive(1'b1, 32'h30, 10'h012);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 10'h0);
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin failures++;
      $display("FAIL flush_input: valid=%b occ=%0d expected 0/0", out_valid, occupancy); end
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++;
        $display("FAIL flush_input_leak[%0d]: valid=%b pc4=%h expected invalid", i, out_valid,
                 out_pc4); end
    end
  endtask

  task automatic test_bubble_mask();
    out_ready = 1'b1;
    drive(1'b1, 32'h40, 10'h3FF);
    tick();
    checks++; if (out_valid !== 1'b1 || out_ctrl !== 10'h3FF) begin failures++;
      $display("FAIL bubble_live: valid=%b ctrl=%h expected 1/3FF", out_valid, out_ctrl); end
    drive(1'b0, 32'h0, 10'h0);
    tick();
    checks++; if (out_valid !== 1'b0 || out_ctrl !== 10'h000) begin failures++;
      $display("FAIL bubble_mask: valid=%b ctrl=%h expected 0/000", out_valid, out_ctrl); end
    // Non-control fields still show the stale MAIN entry
    checks++; if (out_pc4 !== 32'h40) begin failures++;
      $display("FAIL bubble_payload: pc4=%h expected 40", out_pc4); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive(1'b1, 32'h50, 10'h3C0);
    tick();
    drive(1'b1, 32'h54, 10'h3C0);
    tick();
    drive(1'b0, 32'h0, 10'h0);
    checks++; if (occupancy !== 2'd2) begin failures++;
      $display("FAIL async_setup: occ=%0d expected 2", occupancy); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || occupancy !== 2'd0)
      begin failures++;
      $display("FAIL async_reset: valid=%b in_ready=%b occ=%0d expected 0/0/0", out_valid,
               in_ready, occupancy); end
    checks++; if (out_ctrl !== 10'h000 || out_pc4 !== 32'h0) begin failures++;
      $display("FAIL async_payload: ctrl=%h pc4=%h expected 000/0", out_ctrl, out_pc4); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++;
      $display("FAIL async_recover: in_ready=%b valid=%b expected 1/0", in_ready, out_valid); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_stream();
    test_stall();
    test_flush_full();
    test_flush_input();
    test_bubble_mask();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
